// File: rtl/flag_pkg.sv
// Shared types for carry/zero flag hazard tracking in the 5-stage pipeline.
// Also holds the decoder constant that marks flag-consuming branches.
package flag_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic carry;
    logic zero;
  } flags_t;

  // Conditional-branch major opcode; the decoder raises id_reads_flags on it.
  localparam logic [5:0] OP_BRANCH_COND = 6'b000101;

  function automatic logic is_flag_branch(input logic [5:0] opcode);
    return opcode == OP_BRANCH_COND;
  endfunction

endpackage

// File: rtl/flag_track_stage.sv
// One pipeline stage of flag-producer tracking: a valid bit plus the flags the
// producer carries, advancing with the pipeline and frozen while it is held.
module flag_track_stage
  import flag_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   advance,
  input  logic   load_flags,
  input  logic   in_v,
  input  flags_t in_flags,
  output logic   out_v,
  output flags_t out_flags
);

  // Flags only load when the upstream slot holds a producer, so stale values persist.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v     <= 1'b0;
      out_flags <= '0;
    end else if (advance) begin
      out_v <= in_v;
      if (load_flags) begin
        out_flags <= in_flags;
      end
    end
  end

endmodule

// File: rtl/flag_hazard_ctrl.sv
// Carry/zero flag hazard scheduler: forwards in-flight flags to ID, stalls
// when the producer is still in EX, and counts stall cycles (saturating).
module flag_hazard_ctrl
  import flag_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_reads_flags,
  input  logic             id_writes_flags,
  input  logic             ex_carry,
  input  logic             ex_zero,
  input  logic             pipe_hold,
  input  logic             flush,
  output logic             flag_stall,
  output logic [1:0]       fwd_sel,
  output logic             fwd_carry,
  output logic             fwd_zero,
  output logic             carry_q,
  output logic             zero_q,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic     advance;
  logic     ex_v;
  logic     mem_v;
  logic     wb_v;
  flags_t   ex_flags;
  flags_t   mem_flags;
  flags_t   wb_flags;
  flags_t   committed;
  flags_t   fwd_flags;
  fwd_sel_t sel;

  assign advance  = !pipe_hold;
  assign ex_flags = '{carry: ex_carry, zero: ex_zero};

  // A flush kills the consumer in ID, so it can never be the reason to stall.
  assign flag_stall = id_valid & id_reads_flags & ex_v & !flush;

  flag_track_stage u_mem (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .load_flags (ex_v),
    .in_v       (ex_v),
    .in_flags   (ex_flags),
    .out_v      (mem_v),
    .out_flags  (mem_flags)
  );

  flag_track_stage u_wb (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .load_flags (1'b1),
    .in_v       (mem_v),
    .in_flags   (mem_flags),
    .out_v      (wb_v),
    .out_flags  (wb_flags)
  );

  // Youngest producer wins: MEM before WB before the committed register.
  always_comb begin
    sel       = FWD_REG;
    fwd_flags = committed;
    if (mem_v) begin
      sel       = FWD_MEM;
      fwd_flags = mem_flags;
    end else if (wb_v) begin
      sel       = FWD_WB;
      fwd_flags = wb_flags;
    end
  end

  assign fwd_sel   = sel;
  assign fwd_carry = fwd_flags.carry;
  assign fwd_zero  = fwd_flags.zero;
  assign carry_q   = committed.carry;
  assign zero_q    = committed.zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v      <= 1'b0;
      committed <= '0;
      stall_cnt <= '0;
    end else if (advance) begin
      ex_v <= id_valid & id_writes_flags & !flag_stall & !flush;
      if (wb_v) begin
        committed <= wb_flags;
      end
      if (flag_stall && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/flag_hazard_ctrl.md
# flag_hazard_ctrl

Scheduler for carry/zero flag dependencies in the 5-stage pipeline (IF/ID/EX/MEM/WB). Tracks in-flight flag-writing instructions in EX, MEM and WB and holds the committed carry/zero register. For a flag-consuming instruction in ID, it selects the flag source (committed, MEM, WB) or stalls ID for one cycle when the producer is still in EX. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_reads_flags  in  1  ID instruction consumes carry/zero (conditional branch, add-with-carry)
- id_writes_flags  in  1  ID instruction updates carry/zero
- ex_carry, ex_zero  in  1 each  flags computed by the ALU in EX this cycle
- pipe_hold  in  1  global freeze from other hazard sources; no stage advances
- flush  in  1  kill the instruction in ID (taken branch)
- flag_stall  out  1  hold IF/ID, inject bubble into EX
- fwd_sel  out  2  flag source for ID: 0 committed, 1 MEM, 2 WB
- fwd_carry, fwd_zero  out  1 each  flag values presented to ID
- carry_q, zero_q  out  1 each  committed flags
- stall_cnt  out  CNT_W  saturating count of flag-stall cycles

## Operation
- Tracking regs: ex_v; mem_v with mem_c/mem_z; wb_v with wb_c/wb_z.
- flag_stall (combinational) = id_valid & id_reads_flags & ex_v & !flush.
- Forward select is combinational with youngest-first priority:
  - mem_v → fwd_sel=1, flags from mem_c/mem_z.
  - else wb_v → fwd_sel=2, flags from wb_c/wb_z.
  - else fwd_sel=0, flags from carry_q/zero_q.
  - fwd_sel value 3 is never driven.
- On each rising edge with !pipe_hold:
  - ex_v ← id_valid & id_writes_flags & !flag_stall & !flush.
  - mem_v ← ex_v; mem_c/mem_z ← ex_carry/ex_zero (captured only when ex_v, else held).
  - wb_v ← mem_v; wb_c/wb_z ← mem_c/mem_z.
  - If wb_v: carry_q/zero_q ← wb_c/wb_z.
  - If flag_stall and stall_cnt ≠ all-ones: stall_cnt increments.
- With pipe_hold=1: every register holds. Outputs are still recomputed from the held state, so flag_stall may be asserted while frozen but is not counted.
- A flagged instruction that is both reader and writer behaves as reader in ID and writer once it enters EX.

## Timing
- Reset (async, immediate): ex_v=mem_v=wb_v=0, all captured flags=0, carry_q=zero_q=0, stall_cnt=0. Outputs: flag_stall=0, fwd_sel=0, fwd_carry=fwd_zero=0.
- Producer-to-consumer latency:
  - Distance 1 (producer in EX): exactly 1 stall cycle, then MEM forward.
  - Distance 2: MEM forward, no stall.
  - Distance 3: WB forward.
  - Distance ≥4: committed register.
- Committed flags update on the edge ending the producer's WB cycle (3 advancing edges after EX entry).
- Simultaneous events:
  - flush with flag_stall candidate: flush wins. No stall, no count, bubble into EX.
  - flush with id_writes_flags: the instruction is not tracked.
  - Back-to-back writers: MEM priority always yields the youngest value.
- Reset mid-stall: state clears at once and flag_stall drops in the same cycle.
- Counter saturates at 2^CNT_W−1 and never wraps.

## Structure
- Shared package flag_pkg:
  - fwd_sel_t enum: FWD_REG=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2.
  - flags_t struct: carry, zero.
  - The branch opcode constant used by the decoder to generate id_reads_flags.
- One sub-module, flag_track_stage: valid bit plus flags_t register with advance/hold and async reset. Instantiated for MEM and WB. ex_v stays a plain flop.

## Test plan
- Reset: assert rst mid-run with mem_v=1 → all outputs 0 immediately; carry_q=0, stall_cnt=0.
- Adjacent dependency: writer (ex_carry=1, ex_zero=0) then branch reader → flag_stall=1 for exactly 1 cycle, stall_cnt=1. Next cycle fwd_sel=1, fwd_carry=1, fwd_zero=0.
- Distance-3 and commit: writer (carry=0, zero=1), two non-flag instructions, then reader → no stall, fwd_sel=2, fwd_zero=1. One cycle later carry_q=0, zero_q=1, fwd_sel=0.
- Back-to-back writers: carry=1 then carry=0, reader at distance 2 → fwd_sel=1, fwd_carry=0 (youngest wins).
- Hold and flush:
  - pipe_hold=1 for 3 cycles during a pending stall → flag_stall stays 1, stall_cnt unchanged, state frozen.
  - flush with a writer in ID → ex_v=0 next cycle, no forwarding later.
- Saturation: CNT_W=2, force 5 stall cycles → stall_cnt stops at 3.
